// File: rtl/router_pkg.sv
// Shared constants and helpers for the 1x3 router output-side controller.
package router_pkg;

  localparam int NUM_PORTS       = 3;
  localparam int DEFAULT_TIMEOUT = 30;

  typedef enum logic [1:0] {
    ADDR_P0   = 2'b00,
    ADDR_P1   = 2'b01,
    ADDR_P2   = 2'b10,
    ADDR_NONE = 2'b11
  } addr_t;

  // One-hot write-enable pattern for a latched destination; no-port gives zero.
  function automatic logic [NUM_PORTS-1:0] addr_onehot(input addr_t a);
    logic [NUM_PORTS-1:0] oh;
    case (a)
      ADDR_P0: oh = 3'b001;
      ADDR_P1: oh = 3'b010;
      ADDR_P2: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/router_sync_if.sv
// Bundle between router_fsm / FIFOs / destinations and router_sync.
// addr_err exists only when ROUTER_SYNC_ADDR_ERR_EN is defined.
interface router_sync_if;

  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
`ifdef ROUTER_SYNC_ADDR_ERR_EN
  logic       addr_err;
`endif

  modport master (
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    input  addr_err,
`endif
    output detect_add, data_in, write_enb_reg,
    output empty_0, empty_1, empty_2,
    output full_0, full_1, full_2,
    output read_enb_0, read_enb_1, read_enb_2,
    input  write_enb, fifo_full,
    input  vld_out_0, vld_out_1, vld_out_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2
  );

  modport slave (
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    output addr_err,
`endif
    input  detect_add, data_in, write_enb_reg,
    input  empty_0, empty_1, empty_2,
    input  full_0, full_1, full_2,
    input  read_enb_0, read_enb_1, read_enb_2,
    output write_enb, fifo_full,
    output vld_out_0, vld_out_1, vld_out_2,
    output soft_reset_0, soft_reset_1, soft_reset_2
  );

endinterface

// File: rtl/router_sync_timer.sv
// Per-port read-timeout: counts consecutive stall cycles (valid but unread)
// and emits a one-cycle registered soft_reset pulse every TIMEOUT stalls.
module router_sync_timer #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld_out,
  input  logic read_enb,
  output logic soft_reset
);

  logic [CNT_W-1:0] cnt_r;
  logic             soft_reset_r;
  logic             stall_s;

  assign stall_s = vld_out & ~read_enb;

  // Stall counter; wraps to zero on the cycle the pulse is issued.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_r        <= {CNT_W{1'b0}};
      soft_reset_r <= 1'b0;
    end else if (stall_s) begin
      if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
        cnt_r        <= {CNT_W{1'b0}};
        soft_reset_r <= 1'b1;
      end else begin
        cnt_r        <= cnt_r + CNT_W'(1);
        soft_reset_r <= 1'b0;
      end
    end else begin
      cnt_r        <= {CNT_W{1'b0}};
      soft_reset_r <= 1'b0;
    end
  end

  assign soft_reset = soft_reset_r;

endmodule

// File: rtl/router_sync.sv
// router_sync: destination latch, one-hot FIFO write steering, full-flag return,
// per-port valid and read-timeout. Optional addr_err via ROUTER_SYNC_ADDR_ERR_EN.
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 5
) (
  input  logic          clock,
  input  logic          resetn,
  router_sync_if.slave  bus
);

  addr_t                addr_r;
  logic [NUM_PORTS-1:0] write_enb_s;
  logic                 fifo_full_s;
  logic [NUM_PORTS-1:0] vld_out_s;
  logic [NUM_PORTS-1:0] read_enb_s;
  logic [NUM_PORTS-1:0] full_s;
  logic [NUM_PORTS-1:0] soft_reset_s;

  assign vld_out_s  = ~{bus.empty_2, bus.empty_1, bus.empty_0};
  assign read_enb_s = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
  assign full_s     = {bus.full_2, bus.full_1, bus.full_0};

  // Destination latch; the header cycle itself still steers with the old value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_r <= ADDR_NONE;
    end else if (bus.detect_add) begin
      addr_r <= addr_t'(bus.data_in);
    end else begin
      addr_r <= addr_r;
    end
  end

  // Write steering to the addressed FIFO.
  always_comb begin
    write_enb_s = 3'b000;
    if (bus.write_enb_reg) begin
      write_enb_s = addr_onehot(addr_r);
    end else begin
      write_enb_s = 3'b000;
    end
  end

  // Full flag of the addressed FIFO back to the FSM.
  always_comb begin
    fifo_full_s = 1'b0;
    case (addr_r)
      ADDR_P0: fifo_full_s = full_s[0];
      ADDR_P1: fifo_full_s = full_s[1];
      ADDR_P2: fifo_full_s = full_s[2];
      default: fifo_full_s = 1'b0;
    endcase
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clock      (clock),
      .resetn     (resetn),
      .vld_out    (vld_out_s[i]),
      .read_enb   (read_enb_s[i]),
      .soft_reset (soft_reset_s[i])
    );
  end

`ifdef ROUTER_SYNC_ADDR_ERR_EN
  logic addr_err_r;

  // Sticky flag for a header naming no port; any valid header clears it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_err_r <= 1'b0;
    end else if (bus.detect_add) begin
      addr_err_r <= (bus.data_in == ADDR_NONE);
    end else begin
      addr_err_r <= addr_err_r;
    end
  end

  assign bus.addr_err = addr_err_r;
`endif

  assign bus.write_enb    = write_enb_s;
  assign bus.fifo_full    = fifo_full_s;
  assign bus.vld_out_0    = vld_out_s[0];
  assign bus.vld_out_1    = vld_out_s[1];
  assign bus.vld_out_2    = vld_out_s[2];
  assign bus.soft_reset_0 = soft_reset_s[0];
  assign bus.soft_reset_1 = soft_reset_s[1];
  assign bus.soft_reset_2 = soft_reset_s[2];

endmodule

// File: tb/tb_router_sync.sv
// Directed, table-driven bench for router_sync plus multi-cycle timeout/latency sequences.
module tb_router_sync;

  localparam int TO = 30;

  logic clock;
  logic resetn;
  int   errors;
  int   checks;

  router_sync_if bus ();

  router_sync #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] addr;
    logic       wr;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] exp_we;
    logic       exp_ff;
    logic [2:0] exp_vld;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_full(input logic [2:0] f);
    bus.full_0 = f[0]; bus.full_1 = f[1]; bus.full_2 = f[2];
  endtask

  task automatic set_empty(input logic [2:0] e);
    bus.empty_0 = e[0]; bus.empty_1 = e[1]; bus.empty_2 = e[2];
  endtask

  task automatic set_rd(input logic [2:0] r);
    bus.read_enb_0 = r[0]; bus.read_enb_1 = r[1]; bus.read_enb_2 = r[2];
  endtask

  task automatic header(input logic [1:0] a);
    bus.detect_add    = 1'b1;
    bus.data_in       = a;
    bus.write_enb_reg = 1'b0;
    step();
    bus.detect_add    = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    resetn = 1'b0;
    bus.detect_add    = 1'b0;
    bus.data_in       = 2'b00;
    bus.write_enb_reg = 1'b0;
    set_empty(3'b111);
    set_full(3'b000);
    set_rd(3'b111);

    vecs[0] = '{addr: 2'd1, wr: 1'b1, full: 3'b000, empty: 3'b111, exp_we: 3'b010, exp_ff: 1'b0, exp_vld: 3'b000};
    vecs[1] = '{addr: 2'd1, wr: 1'b1, full: 3'b010, empty: 3'b111, exp_we: 3'b010, exp_ff: 1'b1, exp_vld: 3'b000};
    vecs[2] = '{addr: 2'd1, wr: 1'b1, full: 3'b001, empty: 3'b111, exp_we: 3'b010, exp_ff: 1'b0, exp_vld: 3'b000};
    vecs[3] = '{addr: 2'd1, wr: 1'b0, full: 3'b010, empty: 3'b111, exp_we: 3'b000, exp_ff: 1'b1, exp_vld: 3'b000};
    vecs[4] = '{addr: 2'd0, wr: 1'b1, full: 3'b001, empty: 3'b110, exp_we: 3'b001, exp_ff: 1'b1, exp_vld: 3'b001};
    vecs[5] = '{addr: 2'd2, wr: 1'b1, full: 3'b100, empty: 3'b011, exp_we: 3'b100, exp_ff: 1'b1, exp_vld: 3'b100};
    vecs[6] = '{addr: 2'd2, wr: 1'b1, full: 3'b011, empty: 3'b000, exp_we: 3'b100, exp_ff: 1'b0, exp_vld: 3'b111};
    vecs[7] = '{addr: 2'd3, wr: 1'b1, full: 3'b111, empty: 3'b101, exp_we: 3'b000, exp_ff: 1'b0, exp_vld: 3'b010};

    // Reset values
    #12;
    chk("rst_write_enb", {29'd0, bus.write_enb}, 32'd0);
    chk("rst_fifo_full", {31'd0, bus.fifo_full}, 32'd0);
    chk("rst_soft_reset", {29'd0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}, 32'd0);
    chk("rst_vld_out", {29'd0, bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}, 32'd0);
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    chk("rst_addr_err", {31'd0, bus.addr_err}, 32'd0);
`endif
    resetn = 1'b1;

    // Write request before any header: no port addressed
    step();
    bus.write_enb_reg = 1'b1;
    set_full(3'b111);
    #1;
    chk("nohdr_write_enb", {29'd0, bus.write_enb}, 32'd0);
    chk("nohdr_fifo_full", {31'd0, bus.fifo_full}, 32'd0);

    // Table of steering / full / valid vectors
    for (int i = 0; i < 8; i++) begin
      header(vecs[i].addr);
      bus.write_enb_reg = vecs[i].wr;
      set_full(vecs[i].full);
      set_empty(vecs[i].empty);
      #1;
      chk($sformatf("vec%0d_write_enb", i), {29'd0, bus.write_enb}, {29'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_fifo_full", i), {31'd0, bus.fifo_full}, {31'd0, vecs[i].exp_ff});
      chk($sformatf("vec%0d_vld_out", i), {29'd0, bus.vld_out_2, bus.vld_out_1, bus.vld_out_0},
          {29'd0, vecs[i].exp_vld});
    end
    bus.write_enb_reg = 1'b0;
    set_full(3'b000);

    // Timeout on port 2: pulse exactly after the 30th stall edge
    set_empty(3'b011);
    set_rd(3'b111);
    step();
    set_rd(3'b011);
    for (int k = 1; k <= TO + 1; k++) begin
      step();
      chk($sformatf("to_sr2_e%0d", k), {31'd0, bus.soft_reset_2}, {31'd0, (k == TO)});
      chk($sformatf("to_sr01_e%0d", k), {30'd0, bus.soft_reset_1, bus.soft_reset_0}, 32'd0);
    end

    // One read at cycle 20 restarts the count
    set_rd(3'b111);
    step();
    for (int k = 1; k <= 51; k++) begin
      set_rd((k == 20) ? 3'b111 : 3'b011);
      step();
      chk($sformatf("restart_sr2_e%0d", k), {31'd0, bus.soft_reset_2}, {31'd0, (k == 50)});
    end
    set_rd(3'b111);
    set_empty(3'b111);
    step();

    // Header during a write: old address steers this cycle, new one next cycle
    header(2'b00);
    bus.detect_add    = 1'b1;
    bus.data_in       = 2'b10;
    bus.write_enb_reg = 1'b1;
    #1;
    chk("hdr_same_cycle", {29'd0, bus.write_enb}, 32'd1);
    step();
    bus.detect_add = 1'b0;
    #1;
    chk("hdr_next_cycle", {29'd0, bus.write_enb}, 32'd4);
    #2;
    resetn = 1'b0;
    #1;
    chk("midpkt_rst_write_enb", {29'd0, bus.write_enb}, 32'd0);
    step();
    resetn = 1'b1;
    #1;
    chk("post_rst_write_enb", {29'd0, bus.write_enb}, 32'd0);

    // Invalid header suppresses writes; a valid header recovers
    header(2'b11);
    bus.write_enb_reg = 1'b1;
    #1;
    chk("bad_hdr_write_enb", {29'd0, bus.write_enb}, 32'd0);
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    chk("bad_hdr_addr_err", {31'd0, bus.addr_err}, 32'd1);
    step();
    chk("addr_err_sticky", {31'd0, bus.addr_err}, 32'd1);
`endif
    header(2'b00);
    bus.write_enb_reg = 1'b1;
    #1;
    chk("good_hdr_write_enb", {29'd0, bus.write_enb}, 32'd1);
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    chk("good_hdr_addr_err", {31'd0, bus.addr_err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_sync.md
# router_sync

Output-side controller for the 1x3 router. Latches the destination address from the header byte when `router_fsm` asserts `detect_add`, steers `write_enb_reg` to exactly one of the three output FIFOs, and returns that FIFO's full flag to the FSM. It also drives the per-port `vld_out` flags and runs a per-port read-timeout counter that issues `soft_reset_0/1/2` to both the FIFO and the FSM when a destination stops reading.

## Interface
Parameters:
- `TIMEOUT`, default 30: consecutive stalled cycles before a port is soft-reset; must be at least 2.
- `CNT_W`, default 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT-1.

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `detect_add`  in  1  from `router_fsm`; header cycle, latch `data_in`.
- `data_in`  in  2  destination address bits of the header byte.
- `write_enb_reg`  in  1  from `router_fsm`; request to write the current byte.
- `empty_0/1/2`  in  1 each  FIFO empty flags.
- `full_0/1/2`  in  1 each  FIFO full flags.
- `read_enb_0/1/2`  in  1 each  destination read enables.
- `write_enb`  out  3  one-hot FIFO write enables.
- `fifo_full`  out  1  full flag of the addressed FIFO, to `router_fsm`.
- `vld_out_0/1/2`  out  1 each  output data valid.
- `soft_reset_0/1/2`  out  1 each  timeout reset pulse, to the FIFO and `router_fsm`.
- `addr_err`  out  1  present only with `ROUTER_SYNC_ADDR_ERR_EN`.

## Operation
- Address register `addr` (2 bits):
  - Loads `data_in` on a rising edge where `detect_add`=1; otherwise holds.
  - Resets to 2'b11, the no-port encoding.
- `write_enb` is combinational:
  - `write_enb_reg`=1 and `addr`=0/1/2 → 3'b001/3'b010/3'b100.
  - `addr`=3, or `write_enb_reg`=0 → 3'b000.
- `fifo_full` is combinational: `full_<addr>`; 0 when `addr`=3.
- `vld_out_i` = ~`empty_i`, combinational and independent per port.
- Timeout counter per port i (`cnt_i`, CNT_W bits; reset value 0):
  - Stall cycle: `vld_out_i`=1 and `read_enb_i`=0.
  - On a stall edge with `cnt_i` < TIMEOUT-1: increment `cnt_i`; `soft_reset_i` <= 0.
  - On a stall edge with `cnt_i` == TIMEOUT-1: `soft_reset_i` <= 1 and `cnt_i` <= 0.
  - On any non-stall edge: `cnt_i` <= 0 and `soft_reset_i` <= 0.
  - Result: `soft_reset_i` is a registered one-cycle pulse. If the stall persists, it repeats every TIMEOUT cycles.
- Ports never interact; any combination of simultaneous timeouts is legal.

## Timing
- Output reset values: `write_enb`=0, `fifo_full`=0, `soft_reset_*`=0, `addr_err`=0. `vld_out_i` follows `empty_i`.
- Address latency: the header's `write_enb` uses the address latched at the previous edge. When `detect_add` and `write_enb_reg` are high in the same cycle, the old `addr` drives `write_enb`; the new address takes effect the following cycle.
- Zero-cycle paths: `write_enb`, `fifo_full`, `vld_out_*`.
- Timeout latency: a stall beginning at edge 1 produces `soft_reset_i`=1 after edge TIMEOUT, when it has been sampled TIMEOUT consecutive times. A single non-stall cycle restarts the count.
- Reset asserted mid-packet: `addr` immediately becomes 3, so `write_enb`=0; all counters and pulses clear asynchronously.

## Configuration
- `ROUTER_SYNC_ADDR_ERR_EN` defined:
  - Adds the `addr_err` output, a sticky register set on any `detect_add` edge with `data_in`=2'b11.
  - Cleared by `resetn` or by a `detect_add` edge with a valid address.
- Undefined: the `addr_err` port and its register do not exist. Invalid addresses silently suppress writes.

## Structure
- Shared package `router_pkg`:
  - `NUM_PORTS`=3.
  - Address encodings `ADDR_P0`/`ADDR_P1`/`ADDR_P2`, `ADDR_NONE`=2'b11.
  - Default `TIMEOUT` constant.
- Sub-module `router_sync_timer`, instantiated three times: `vld_out`, `read_enb`, counter and `soft_reset` pulse for one port.

## Test plan
- Reset, then `write_enb_reg`=1 before any header → `write_enb`=3'b000 and `fifo_full`=0.
- `detect_add`=1 with `data_in`=2'b01, then `write_enb_reg`=1 → `write_enb`=3'b010. `full_1`=1 → `fifo_full`=1; `full_0`=1 alone → `fifo_full`=0.
- `empty_2`=0 and `read_enb_2`=0 for 30 cycles → `soft_reset_2` high for exactly one cycle after the 30th edge; `soft_reset_0/1` stay 0.
- Same stall, but `read_enb_2`=1 for one cycle at cycle 20 → no pulse until 30 cycles after that cycle.
- Header with `data_in`=2'b10 while `write_enb_reg`=1 and `addr`=0 → that cycle `write_enb`=3'b001, next cycle 3'b100. Assert `resetn`=0 mid-packet → `write_enb`=0 immediately.
- With `ROUTER_SYNC_ADDR_ERR_EN`: header `data_in`=2'b11 → `addr_err`=1 and `write_enb`=0. Next header 2'b00 → `addr_err`=0.
